// File: rtl/button_reader.sv
// button_reader: synchronizes and debounces a raw push-button pin, producing a
// clean level, one-cycle press/release pulses, an optional long-press pulse and
// a wrapping press counter.
//
// Optional feature: define BUTTON_READER_LONG_PRESS_EN to build the hold
// counter and the long_press pulse. Without it long_press is tied low.
//
// The release event port is named release_pulse because "release" is a
// reserved word in SystemVerilog.

module button_reader #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned LONG_CYCLES     = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btnpin,
   output logic       level,
   output logic       press,
   output logic       release_pulse,
   output logic       long_press,
   output logic [7:0] press_count
);

   localparam int unsigned CNT_W   = 26;
   localparam int unsigned COUNT_W = 8;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Reject configurations the 26-bit counters cannot represent.
   if (DEBOUNCE_CYCLES == 0 || DEBOUNCE_CYCLES > (1 << CNT_W) ||
       LONG_CYCLES == 0 || LONG_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
      $error("button_reader: DEBOUNCE_CYCLES/LONG_CYCLES out of range");
   end

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

   logic [1:0]         sync_q;
   logic               s;
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               level_d;
   logic               press_d;
   logic               release_d;
   logic [COUNT_W-1:0] count_d;

   // Two-flop synchronizer; s is the only internal view of the pin.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], btnpin};
      end
   end

   assign s = sync_q[1];

   // State, debounce counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         level         <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         press_count   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         level         <= level_d;
         press         <= press_d;
         release_pulse <= release_d;
         press_count   <= count_d;
      end
   end

   // Debounce FSM: a new level is accepted only after it stays stable.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level;
      press_d   = 1'b0;
      release_d = 1'b0;
      count_d   = press_count;

      case (state_q)
         IDLE: begin
            if (s) begin
               state_d = DB_PRESS;
               cnt_d   = '0;
            end
         end

         DB_PRESS: begin
            if (!s) begin
               state_d = IDLE;
            end else if (cnt_q == DB_LAST) begin
               state_d = HELD;
               level_d = 1'b1;
               press_d = 1'b1;
               count_d = press_count + COUNT_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         HELD: begin
            if (!s) begin
               state_d = DB_RELEASE;
               cnt_d   = '0;
            end
         end

         DB_RELEASE: begin
            if (s) begin
               state_d = HELD;
            end else if (cnt_q == DB_LAST) begin
               state_d   = IDLE;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef BUTTON_READER_LONG_PRESS_EN

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_MAX  = '1;

   logic [CNT_W-1:0] hold_q, hold_d;
   logic             armed_q, armed_d;
   logic             long_d;
   logic             hold_inc;

   // Hold counter, one-shot arm flag and registered long_press pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q     <= '0;
         armed_q    <= 1'b0;
         long_press <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         armed_q    <= armed_d;
         long_press <= long_d;
      end
   end

   // Arm on a confirmed press, disarm on release or after firing once.
   always_comb begin
      hold_d   = hold_q;
      armed_d  = armed_q;
      long_d   = 1'b0;
      hold_inc = 1'b0;

      if (press_d) begin
         hold_d  = '0;
         armed_d = 1'b1;
      end else if (release_d) begin
         hold_d  = '0;
         armed_d = 1'b0;
      end else if (level && (hold_q != HOLD_MAX)) begin
         hold_d   = hold_q + CNT_W'(1);
         hold_inc = 1'b1;
      end

      if (hold_inc && armed_q && (hold_d == LONG_LAST)) begin
         long_d  = 1'b1;
         armed_d = 1'b0;
      end
   end

`else

   assign long_press = 1'b0;

`endif

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader (DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// A behavioural model tracks the pin through a two-sample delay and accepts a
// new level once it has been seen for DEBOUNCE_CYCLES+1 consecutive samples.

module tb_button_reader;

   localparam int unsigned DB = 4;
   localparam int unsigned LC = 20;
`ifdef BUTTON_READER_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       btnpin;
   logic       level;
   logic       press;
   logic       release_pulse;
   logic       long_press;
   logic [7:0] press_count;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic       m_p1, m_p2, m_runv;
   int         m_run;
   logic       m_level, m_press, m_rel, m_long;
   logic [7:0] m_count;
   int         m_age;

   button_reader #(
      .DEBOUNCE_CYCLES(DB),
      .LONG_CYCLES    (LC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btnpin       (btnpin),
      .level        (level),
      .press        (press),
      .release_pulse(release_pulse),
      .long_press   (long_press),
      .press_count  (press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance the model by one rising edge.
   task automatic model_edge(input logic pin, input logic r);
      logic s;
      m_press = 1'b0;
      m_rel   = 1'b0;
      m_long  = 1'b0;
      if (r) begin
         m_p1 = 1'b0; m_p2 = 1'b0; m_runv = 1'b0; m_run = 0;
         m_level = 1'b0; m_count = 8'd0; m_age = -1;
      end else begin
         s    = m_p2;
         m_p2 = m_p1;
         m_p1 = pin;
         if (s == m_runv) m_run++;
         else begin
            m_runv = s;
            m_run  = 1;
         end
         if (m_run >= int'(DB) + 1 && s != m_level) begin
            m_level = s;
            if (s) begin
               m_press = 1'b1;
               m_count = m_count + 8'd1;
               m_age   = 0;
            end else begin
               m_rel = 1'b1;
               m_age = -1;
            end
         end else if (m_level && m_age >= 0) begin
            m_age++;
            m_long = LONG_EN && (m_age == int'(LC) - 1);
         end
      end
   endtask

   task automatic check_all();
      chk("level", 32'(level), 32'(m_level));
      chk("press", 32'(press), 32'(m_press));
      chk("release", 32'(release_pulse), 32'(m_rel));
      chk("long_press", 32'(long_press), 32'(m_long));
      chk("press_count", 32'(press_count), 32'(m_count));
      chk("pulse_overlap", 32'((press & release_pulse) | (press & long_press) |
                               (release_pulse & long_press)), 32'd0);
   endtask

   // Drive one cycle: inputs set away from the edge, outputs checked at negedge.
   task automatic step(input logic pin, input logic r);
      btnpin = pin;
      rst    = r;
      @(posedge clk);
      model_edge(pin, r);
      @(negedge clk);
      check_all();
   endtask

   int   edge_n, press_edge, long_edge, rel_edge;
   int   n_press, n_rel, n_long, len;
   logic v, r;

   initial begin
      btnpin = 1'b0;
      rst    = 1'b1;
      m_p1 = 1'b0; m_p2 = 1'b0; m_runv = 1'b0; m_run = 0;
      m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
      m_count = 8'd0; m_age = -1;
      @(negedge clk);

      // reset state
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("reset_level", 32'(level), 32'd0);
      chk("reset_count", 32'(press_count), 32'd0);

      // short 3-cycle blip is rejected
      n_press = 0;
      for (int i = 0; i < 3; i++) begin step(1'b1, 1'b0); n_press += int'(press); end
      for (int i = 0; i < 10; i++) begin step(1'b0, 1'b0); n_press += int'(press); end
      chk("blip_press", 32'(n_press), 32'd0);
      chk("blip_level", 32'(level), 32'd0);
      chk("blip_count", 32'(press_count), 32'd0);

      // held press: latency, single pulse, long press
      edge_n = 0; press_edge = -1; long_edge = -1; n_press = 0; n_long = 0;
      for (int i = 0; i < 37; i++) begin
         step(1'b1, 1'b0);
         edge_n++;
         if (press) begin n_press++; if (press_edge < 0) press_edge = edge_n; end
         if (long_press) begin n_long++; if (long_edge < 0) long_edge = edge_n; end
      end
      chk("press_latency", 32'(press_edge), 32'd7);
      chk("press_pulses", 32'(n_press), 32'd1);
      chk("held_level", 32'(level), 32'd1);
      chk("held_count", 32'(press_count), 32'd1);
      chk("long_pulses", 32'(n_long), LONG_EN ? 32'd1 : 32'd0);
      chk("long_gap", 32'((long_edge < 0) ? -1 : long_edge - press_edge),
          LONG_EN ? 32'd19 : 32'hFFFF_FFFF);

      // 2-cycle low glitch while held
      n_rel = 0;
      for (int i = 0; i < 2; i++) begin step(1'b0, 1'b0); n_rel += int'(release_pulse); end
      for (int i = 0; i < 10; i++) begin step(1'b1, 1'b0); n_rel += int'(release_pulse); end
      chk("glitch_release", 32'(n_rel), 32'd0);
      chk("glitch_level", 32'(level), 32'd1);

      // sustained low: release latency
      edge_n = 0; rel_edge = -1; n_rel = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0);
         edge_n++;
         if (release_pulse) begin n_rel++; if (rel_edge < 0) rel_edge = edge_n; end
      end
      chk("release_latency", 32'(rel_edge), 32'd7);
      chk("release_pulses", 32'(n_rel), 32'd1);
      chk("released_level", 32'(level), 32'd0);

      // 256 clean presses wrap the counter
      step(1'b0, 1'b1);
      n_press = 0;
      for (int p = 0; p < 256; p++) begin
         for (int i = 0; i < 8; i++) begin step(1'b1, 1'b0); n_press += int'(press); end
         for (int i = 0; i < 9; i++) step(1'b0, 1'b0);
      end
      chk("wrap_presses", 32'(n_press), 32'd256);
      chk("wrap_count", 32'(press_count), 32'd0);

      // reset while held: outputs clear, no release follows
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
      chk("pre_rst_level", 32'(level), 32'd1);
      step(1'b1, 1'b1);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_press", 32'(press), 32'd0);
      chk("rst_release", 32'(release_pulse), 32'd0);
      chk("rst_long", 32'(long_press), 32'd0);
      chk("rst_count", 32'(press_count), 32'd0);

      // pin still high after reset: full debounce then press
      edge_n = 0; press_edge = -1;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0);
         edge_n++;
         if (press && press_edge < 0) press_edge = edge_n;
      end
      chk("post_rst_press", 32'(press_edge), 32'd7);
      n_rel = 0;
      step(1'b1, 1'b1);
      for (int i = 0; i < 12; i++) begin step(1'b0, 1'b0); n_rel += int'(release_pulse); end
      chk("rst_no_release", 32'(n_rel), 32'd0);

      // random pin activity with occasional reset
      for (int k = 0; k < 1500; k = k + len) begin
         len = int'($urandom_range(1, 12));
         v   = 1'($urandom_range(0, 1));
         for (int j = 0; j < len; j++) begin
            r = ($urandom_range(0, 299) == 0);
            step(v, r);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/button_reader.md
BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high, named as follows.
REQ-002 The block SHALL provide parameter DEBOUNCE_CYCLES, default 1_000_000, the cycles a new input level must stay stable before it is accepted (20 ms at 50 MHz).
REQ-003 The block SHALL provide parameter LONG_CYCLES, default 50_000_000, the confirmed-hold cycles before a long-press event (1 s at 50 MHz).
REQ-004 The block SHALL have port clk, input, 1, the system clock (50 MHz).
REQ-005 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 The block SHALL have port btnpin, input, 1, the raw asynchronous button pin, high = pressed.
REQ-007 The block SHALL have port level, output, 1, the debounced button state.
REQ-008 The block SHALL have port press, output, 1, a one-cycle pulse on each confirmed press.
REQ-009 The block SHALL have port release, output, 1, a one-cycle pulse on each confirmed release.
REQ-010 The block SHALL have port long_press, output, 1, a one-cycle pulse when a hold reaches LONG_CYCLES.
REQ-011 The block SHALL have port press_count, output, 8, the number of confirmed presses, modulo 256.

Function
REQ-012 btnpin SHALL pass through a 2-flop synchronizer; its output s SHALL be the only internal use of the pin.
REQ-013 The FSM SHALL have 4 states: IDLE, DB_PRESS, HELD and DB_RELEASE.
REQ-014 The debounce counter SHALL be 26-bit and run 0..DEBOUNCE_CYCLES-1.
REQ-015 In IDLE, s=1 SHALL move to DB_PRESS with cnt<=0; otherwise the FSM SHALL stay in IDLE.
REQ-016 In DB_PRESS, s=0 SHALL return to IDLE with no output change (glitch rejected).
REQ-017 In DB_PRESS, if s=1 and cnt==DEBOUNCE_CYCLES-1, the FSM SHALL enter HELD, set level<=1, pulse press, and increment press_count; otherwise it SHALL increment cnt.
REQ-018 In HELD, s=0 SHALL move to DB_RELEASE with cnt<=0.
REQ-019 In DB_RELEASE, s=1 SHALL return to HELD with no pulse and no count change (glitch rejected).
REQ-020 In DB_RELEASE, if s=0 and cnt==DEBOUNCE_CYCLES-1, the FSM SHALL enter IDLE, set level<=0 and pulse release; otherwise it SHALL increment cnt.
REQ-021 Press latency SHALL be DEBOUNCE_CYCLES+3 rising edges, counting the first edge that samples btnpin high as edge 1; press is high in the cycle after that edge. Release latency SHALL be the same, measured from low.
REQ-022 press, release and long_press SHALL each be high for exactly one cycle and SHALL never be high in the same cycle.
REQ-023 press_count SHALL wrap from 255 to 0 with no other side effect.
REQ-024 level SHALL change only on the transitions in REQ-017 and REQ-020.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL clear the synchronizer flops, cnt, the hold counter and press_count to 0, set the state to IDLE, and drive all outputs to 0.
REQ-026 Reset asserted in HELD or DB_RELEASE SHALL NOT produce a release pulse.
REQ-027 After reset deasserts with btnpin held high, a full debounce and a press pulse SHALL follow.

Configuration
REQ-028 With macro BUTTON_READER_LONG_PRESS_EN defined, a 26-bit hold counter SHALL clear on entry to HELD and increment while level=1 (through HELD and DB_RELEASE), saturating.
REQ-029 With the macro defined, long_press SHALL pulse once when the hold counter equals LONG_CYCLES-1, at most once per confirmed press.
REQ-030 With the macro defined, the hold counter SHALL clear on confirmed release; a glitch back from DB_RELEASE to HELD SHALL NOT re-arm long_press.
REQ-031 Without the macro, long_press SHALL be constant 0 and no hold counter SHALL be synthesized.

Verification (bench parameters DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-032 The bench SHALL cover: btnpin high for 3 cycles then low -> press never asserts, level stays 0, press_count stays 0.
REQ-033 The bench SHALL cover: btnpin high held, first sampled at edge 1 -> press high after edge 7 for one cycle, level=1, press_count=1.
REQ-034 The bench SHALL cover: in HELD, a 2-cycle low glitch -> no release, level stays 1; a sustained low -> release pulse 7 edges after the low is first sampled, level=0.
REQ-035 The bench SHALL cover, with the macro defined: a press held 30 cycles -> exactly one long_press pulse, 19 cycles after press; without the macro -> long_press stays 0.
REQ-036 The bench SHALL cover: 256 clean presses -> press_count returns to 0.
REQ-037 The bench SHALL cover: rst=1 asserted in HELD -> next cycle all outputs 0 and no release pulse.
